ram_master: RTL and testbench

//  Hardware initiator for the 8-bit-address / 32-bit shared-data RAM port (addr, data_io, rd_en, wr_en).

---
 rtl/ram_master_if.sv | 22 ++
 rtl/ram_master.sv | 119 +++++++++++
 tb/tb_ram_master.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_if.sv
// rtl/ram_master_if.sv - host command/response handshake for ram_master
interface ram_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_wr;
   logic [31:0] rsp_rdata;
   logic        busy;

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, busy
   );
endinterface

// File: rtl/ram_master.sv
// rtl/ram_master.sv - queued command sequencer for the 8-bit-address / 32-bit shared-bus RAM port
module ram_master #(
   parameter int CMD_DEPTH  = 4,
   parameter int STROBE_CYC = 1,
   parameter int RD_LAT     = 0
) (
   input  logic        clk,
   input  logic        reset,
   ram_master_if.slave host,
   output logic [7:0]  ram_addr,
   inout  wire  [31:0] ram_data_io,
   output logic        ram_wr_en,
   output logic        ram_rd_en
);
   localparam int AW     = $clog2(CMD_DEPTH);
   localparam int RD_CYC = STROBE_CYC + RD_LAT;
   localparam int CW     = $clog2(RD_CYC + 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, TURN} state_t;
   state_t state, state_nxt;

   logic [40:0]   fifo_mem [CMD_DEPTH];
   logic [40:0]   head;
   logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic          fifo_empty, full_nxt, push, pop, cmd_ready_q;
   logic          cur_wr, bus_oe, last_strobe, rsp_valid_c;
   logic [31:0]   cur_wdata, rdata_q;
   logic [CW-1:0] cnt;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign push       = host.cmd_valid && cmd_ready_q;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
   assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
   // Pointers carry one extra bit so full and empty differ only in the MSB.
   assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
   assign head       = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {host.cmd_wr, host.cmd_addr, host.cmd_wdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         cmd_ready_q <= !full_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      last_strobe = 1'b0;
      ram_wr_en   = 1'b0;
      ram_rd_en   = 1'b0;
      rsp_valid_c = 1'b0;
      case (state)
         IDLE:   if (!fifo_empty) state_nxt = SETUP;
         SETUP:  state_nxt = STROBE;
         STROBE: begin
            ram_wr_en = cur_wr;
            ram_rd_en = !cur_wr;
            if (cnt == '0) begin
               last_strobe = 1'b1;
               state_nxt   = TURN;
            end
         end
         TURN: begin
            rsp_valid_c = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The command is latched on the pop edge so address and write data are valid throughout SETUP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_addr  <= '0;
         cur_wr    <= 1'b0;
         cur_wdata <= '0;
         bus_oe    <= 1'b0;
         cnt       <= '0;
         rdata_q   <= '0;
      end else begin
         if (pop) begin
            cur_wr    <= head[40];
            ram_addr  <= head[39:32];
            cur_wdata <= head[31:0];
            bus_oe    <= head[40];
         end
         if (state == SETUP) cnt <= cur_wr ? WR_LOAD : RD_LOAD;
         else if (state == STROBE && cnt != '0) cnt <= cnt - 1'b1;
         if (last_strobe) begin
            bus_oe <= 1'b0;
            if (!cur_wr) rdata_q <= ram_data_io;
         end
      end
   end

   assign ram_data_io    = bus_oe ? cur_wdata : 'z;
   assign host.cmd_ready = cmd_ready_q;
   assign host.rsp_valid = rsp_valid_c;
   assign host.rsp_wr    = cur_wr;
   assign host.rsp_rdata = rdata_q;
   assign host.busy      = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - randomized self-checking bench for ram_master against a queue-based RAM model
module tb_ram_master;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   ram_master_if ha();
   ram_master_if hb();
   wire  [31:0] bus_a, bus_b;
   logic [7:0]  addr_a, addr_b;
   logic        wr_a, rd_a, wr_b, rd_b;

   ram_master #(.CMD_DEPTH(4), .STROBE_CYC(1), .RD_LAT(0)) dut_a (
      .clk(clk), .reset(rst_a), .host(ha), .ram_addr(addr_a),
      .ram_data_io(bus_a), .ram_wr_en(wr_a), .ram_rd_en(rd_a));
   ram_master #(.CMD_DEPTH(4), .STROBE_CYC(2), .RD_LAT(2)) dut_b (
      .clk(clk), .reset(rst_b), .host(hb), .ram_addr(addr_b),
      .ram_data_io(bus_b), .ram_wr_en(wr_b), .ram_rd_en(rd_b));

   // RAM devices: drive the bus while rd_en is high, capture on the edge while wr_en is high.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   assign bus_a = rd_a ? mem_a[addr_a] : 'z;
   assign bus_b = rd_b ? mem_b[addr_b] : 'z;
   always @(posedge clk) begin
      if (wr_a) mem_a[addr_a] <= bus_a;
      if (wr_b) mem_b[addr_b] <= bus_b;
   end

   typedef struct {logic wr; logic [7:0] addr; logic [31:0] data;} cmd_t;
   typedef struct {logic wr; logic [31:0] rdata; int cyc;} rsp_t;
   typedef struct {logic wr; logic [7:0] addr; logic [31:0] data; int len;} stb_t;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rsp_t rsp_q[$];
   stb_t strb_q[$];
   stb_t cur_s;
   int   run_a = 0;
   bit   both_seen = 1'b0;
   always @(negedge clk) begin
      if (ha.rsp_valid) rsp_q.push_back('{ha.rsp_wr, ha.rsp_rdata, cyc});
      if (wr_a && rd_a) both_seen = 1'b1;
      if (wr_a || rd_a) begin
         if (run_a == 0) cur_s = '{wr_a, addr_a, bus_a, 0};
         run_a++;
         cur_s.len = run_a;
      end else if (run_a != 0) begin
         strb_q.push_back(cur_s);
         run_a = 0;
      end
   end

   int          wr_cnt_b = 0, rd_cnt_b = 0, rsp_n_b = 0;
   logic        rsp_wr_b;
   logic [31:0] rsp_data_b;
   always @(negedge clk) begin
      if (wr_b) wr_cnt_b++;
      if (rd_b) rd_cnt_b++;
      if (hb.rsp_valid) begin
         rsp_n_b++;
         rsp_wr_b   = hb.rsp_wr;
         rsp_data_b = hb.rsp_rdata;
      end
   end

   // Reference: a flat memory array; commands complete in acceptance order.
   logic [31:0] ref_mem [256];
   bit          written [256];
   cmd_t        exp_q[$];
   int          rsp_i = 0, strb_i = 0;

   task automatic send_a(input logic wr, input logic [7:0] a, input logic [31:0] d, output bit stalled);
      int t = 0;
      stalled      = !ha.cmd_ready;
      ha.cmd_valid = 1'b1;
      ha.cmd_wr    = wr;
      ha.cmd_addr  = a;
      ha.cmd_wdata = d;
      while (!ha.cmd_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
         checks++;
         $display("FAIL accept_timeout: cmd_ready=%b want 1", ha.cmd_ready);
      end
      if (wr) begin
         ref_mem[a] = d;
         written[a] = 1'b1;
         exp_q.push_back('{1'b1, a, d});
      end else begin
         exp_q.push_back('{1'b0, a, ref_mem[a]});
      end
      @(negedge clk);
      ha.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle_a(output bit ok);
      int t = 0;
      @(negedge clk);
      while (ha.busy && t < 300) begin @(negedge clk); t++; end
      ok = !ha.busy;
      @(negedge clk);
   endtask

   task automatic test_reset;
      ha.cmd_valid = 0; ha.cmd_wr = 0; ha.cmd_addr = 0; ha.cmd_wdata = 0;
      hb.cmd_valid = 0; hb.cmd_wr = 0; hb.cmd_addr = 0; hb.cmd_wdata = 0;
      repeat (3) @(negedge clk);
      checks++; if ({wr_a, rd_a} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {wr_a, rd_a}); else passes++;
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      checks++; if (ha.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ha.cmd_ready); else passes++;
      checks++; if (ha.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", ha.rsp_valid); else passes++;
      checks++; if (ha.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ha.busy); else passes++;
      checks++; if (ha.rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ha.rsp_rdata); else passes++;
      checks++; if (addr_a !== 8'h00) $display("FAIL reset_addr: got %h want 00", addr_a); else passes++;
      checks++; if (hb.cmd_ready !== 1'b1) $display("FAIL reset_ready_b: got %b want 1", hb.cmd_ready); else passes++;
   endtask

   task automatic test_write_single;
      bit st, ok;
      int n = 0;
      send_a(1'b1, 8'hFF, 32'd99, st);
      while (!ha.rsp_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (n !== 3) $display("FAIL write_latency: got %0d want 3", n); else passes++;
      checks++; if (ha.rsp_wr !== 1'b1) $display("FAIL write_rsp_wr: got %b want 1", ha.rsp_wr); else passes++;
      wait_idle_a(ok);
      checks++; if (strb_i >= strb_q.size()) $display("FAIL write_strobe: got none want one");
      else if (strb_q[strb_i].wr !== 1'b1 || strb_q[strb_i].addr !== 8'hFF || strb_q[strb_i].data !== 32'd99 || strb_q[strb_i].len !== 1)
         $display("FAIL write_strobe: got wr=%b addr=%h data=%0d len=%0d want 1/ff/99/1",
                  strb_q[strb_i].wr, strb_q[strb_i].addr, strb_q[strb_i].data, strb_q[strb_i].len);
      else passes++;
      strb_i = strb_q.size();
      rsp_i  = rsp_q.size();
      exp_q.delete();
   endtask

   task automatic test_read_back;
      bit st, ok;
      send_a(1'b1, 8'hFE, 32'd77, st);
      send_a(1'b0, 8'hFF, 32'h0, st);
      send_a(1'b0, 8'hFE, 32'h0, st);
      wait_idle_a(ok);
      checks++; if (!ok) $display("FAIL readback_idle: busy=%b want 0", ha.busy); else passes++;
      foreach (exp_q[i]) begin
         checks++;
         if (rsp_i >= rsp_q.size()) $display("FAIL readback_rsp[%0d]: got none want wr=%b", i, exp_q[i].wr);
         else if (rsp_q[rsp_i].wr !== exp_q[i].wr || (!exp_q[i].wr && rsp_q[rsp_i].rdata !== exp_q[i].data))
            $display("FAIL readback_rsp[%0d]: got wr=%b rdata=%0d want wr=%b rdata=%0d", i,
                     rsp_q[rsp_i].wr, rsp_q[rsp_i].rdata, exp_q[i].wr, exp_q[i].data);
         else passes++;
         rsp_i++;
         checks++;
         if (strb_i >= strb_q.size()) $display("FAIL readback_strobe[%0d]: got none want one", i);
         else if (strb_q[strb_i].wr !== exp_q[i].wr || strb_q[strb_i].addr !== exp_q[i].addr ||
                  strb_q[strb_i].data !== exp_q[i].data || strb_q[strb_i].len !== 1)
            $display("FAIL readback_strobe[%0d]: got addr=%h data=%0d len=%0d want addr=%h data=%0d len=1", i,
                     strb_q[strb_i].addr, strb_q[strb_i].data, strb_q[strb_i].len, exp_q[i].addr, exp_q[i].data);
         else passes++;
         strb_i++;
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      bit st, ok;
      int first_stall = -1;
      int r0 = rsp_q.size();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a = 8'($urandom_range(0, 15));
         logic w = ($urandom_range(0, 1) == 1) || !written[a];
         send_a(w, a, $urandom, st);
         if (st && first_stall < 0) first_stall = i;
      end
      wait_idle_a(ok);
      checks++; if (first_stall !== 5) $display("FAIL b2b_stall_index: got %0d want 5", first_stall); else passes++;
      checks++; if (rsp_q.size() - r0 !== 6) $display("FAIL b2b_count: got %0d want 6", rsp_q.size() - r0); else passes++;
      for (int i = r0 + 1; i < rsp_q.size(); i++) begin
         checks++;
         if (rsp_q[i].cyc - rsp_q[i-1].cyc !== 4)
            $display("FAIL b2b_spacing[%0d]: got %0d want 4", i - r0, rsp_q[i].cyc - rsp_q[i-1].cyc);
         else passes++;
      end
      foreach (exp_q[i]) begin
         checks++;
         if (rsp_i >= rsp_q.size()) $display("FAIL b2b_rsp[%0d]: got none want wr=%b", i, exp_q[i].wr);
         else if (rsp_q[rsp_i].wr !== exp_q[i].wr || (!exp_q[i].wr && rsp_q[rsp_i].rdata !== exp_q[i].data))
            $display("FAIL b2b_rsp[%0d]: got wr=%b rdata=%h want wr=%b rdata=%h", i,
                     rsp_q[rsp_i].wr, rsp_q[rsp_i].rdata, exp_q[i].wr, exp_q[i].data);
         else passes++;
         rsp_i++;
      end
      strb_i = strb_q.size();
      exp_q.delete();
   endtask

   task automatic test_alternate;
      bit st, ok;
      logic [7:0] a = 8'($urandom_range(32, 200));
      for (int i = 0; i < 6; i++) begin
         send_a(1'b1, a, $urandom, st);
         send_a(1'b0, a, 32'h0, st);
      end
      wait_idle_a(ok);
      checks++; if (both_seen !== 1'b0) $display("FAIL alt_both_strobes: got %b want 0", both_seen); else passes++;
      foreach (exp_q[i]) begin
         checks++;
         if (strb_i >= strb_q.size()) $display("FAIL alt_bus[%0d]: got none want one", i);
         else if (strb_q[strb_i].wr !== exp_q[i].wr || strb_q[strb_i].data !== exp_q[i].data)
            $display("FAIL alt_bus[%0d]: got wr=%b data=%h want wr=%b data=%h", i,
                     strb_q[strb_i].wr, strb_q[strb_i].data, exp_q[i].wr, exp_q[i].data);
         else passes++;
         strb_i++;
         checks++;
         if (rsp_i >= rsp_q.size()) $display("FAIL alt_rsp[%0d]: got none want wr=%b", i, exp_q[i].wr);
         else if (rsp_q[rsp_i].wr !== exp_q[i].wr || (!exp_q[i].wr && rsp_q[rsp_i].rdata !== exp_q[i].data))
            $display("FAIL alt_rsp[%0d]: got wr=%b rdata=%h want wr=%b rdata=%h", i,
                     rsp_q[rsp_i].wr, rsp_q[rsp_i].rdata, exp_q[i].wr, exp_q[i].data);
         else passes++;
         rsp_i++;
      end
      exp_q.delete();
   endtask

   task automatic test_random;
      bit st, ok;
      for (int i = 0; i < 30; i++) begin
         logic [7:0] a = 8'($urandom_range(0, 15));
         logic w = ($urandom_range(0, 1) == 1) || !written[a];
         send_a(w, a, $urandom, st);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      wait_idle_a(ok);
      checks++; if (!ok) $display("FAIL random_idle: busy=%b want 0", ha.busy); else passes++;
      foreach (exp_q[i]) begin
         checks++;
         if (rsp_i >= rsp_q.size()) $display("FAIL random_rsp[%0d]: got none want wr=%b", i, exp_q[i].wr);
         else if (rsp_q[rsp_i].wr !== exp_q[i].wr || (!exp_q[i].wr && rsp_q[rsp_i].rdata !== exp_q[i].data))
            $display("FAIL random_rsp[%0d]: got wr=%b rdata=%h want wr=%b rdata=%h", i,
                     rsp_q[rsp_i].wr, rsp_q[rsp_i].rdata, exp_q[i].wr, exp_q[i].data);
         else passes++;
         rsp_i++;
         checks++;
         if (strb_i >= strb_q.size()) $display("FAIL random_strobe[%0d]: got none want one", i);
         else if (strb_q[strb_i].addr !== exp_q[i].addr || strb_q[strb_i].data !== exp_q[i].data || strb_q[strb_i].len !== 1)
            $display("FAIL random_strobe[%0d]: got addr=%h data=%h len=%0d want addr=%h data=%h len=1", i,
                     strb_q[strb_i].addr, strb_q[strb_i].data, strb_q[strb_i].len, exp_q[i].addr, exp_q[i].data);
         else passes++;
         strb_i++;
      end
      exp_q.delete();
   endtask

   task automatic test_reset_abort;
      bit st, ok;
      int t = 0;
      logic [31:0] d = $urandom;
      send_a(1'b1, 8'h20, $urandom, st);
      send_a(1'b1, 8'h21, $urandom, st);
      send_a(1'b0, 8'h20, 32'h0, st);
      exp_q.delete();
      written[8'h20] = 1'b0;
      written[8'h21] = 1'b0;
      while (!wr_a && t < 20) begin @(negedge clk); t++; end
      checks++; if (wr_a !== 1'b1) $display("FAIL abort_reach_strobe: got %b want 1", wr_a); else passes++;
      #1 rst_a = 1'b1;
      #1;
      checks++; if (wr_a !== 1'b0) $display("FAIL abort_wr_en: got %b want 0", wr_a); else passes++;
      checks++; if (ha.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", ha.busy); else passes++;
      checks++; if (ha.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid: got %b want 0", ha.rsp_valid); else passes++;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      rsp_i  = rsp_q.size();
      strb_i = strb_q.size();
      repeat (12) @(negedge clk);
      checks++; if (rsp_q.size() !== rsp_i) $display("FAIL abort_no_rsp: got %0d want 0", rsp_q.size() - rsp_i); else passes++;
      checks++; if (strb_q.size() !== strb_i) $display("FAIL abort_no_strobe: got %0d want 0", strb_q.size() - strb_i); else passes++;
      checks++; if (ha.cmd_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ha.cmd_ready); else passes++;
      send_a(1'b1, 8'h22, d, st);
      send_a(1'b0, 8'h22, 32'h0, st);
      wait_idle_a(ok);
      checks++; if (rsp_q.size() - rsp_i !== 2) $display("FAIL abort_recover_count: got %0d want 2", rsp_q.size() - rsp_i); else passes++;
      checks++; if (ha.rsp_rdata !== d) $display("FAIL abort_recover_data: got %h want %h", ha.rsp_rdata, d); else passes++;
      rsp_i  = rsp_q.size();
      strb_i = strb_q.size();
      exp_q.delete();
   endtask

   task automatic test_read_latency;
      int w0 = wr_cnt_b;
      int r0 = rd_cnt_b;
      int n0 = rsp_n_b;
      int t;
      for (int k = 0; k < 2; k++) begin
         hb.cmd_valid = 1'b1;
         hb.cmd_wr    = (k == 0);
         hb.cmd_addr  = 8'h10;
         hb.cmd_wdata = 32'hDEADBEEF;
         t = 0;
         while (!hb.cmd_ready && t < 100) begin @(negedge clk); t++; end
         @(negedge clk);
         hb.cmd_valid = 1'b0;
      end
      t = 0;
      while (rsp_n_b < n0 + 2 && t < 200) begin @(negedge clk); t++; end
      checks++; if (rsp_n_b - n0 !== 2) $display("FAIL lat_rsp_count: got %0d want 2", rsp_n_b - n0); else passes++;
      checks++; if (wr_cnt_b - w0 !== 2) $display("FAIL lat_wr_cycles: got %0d want 2", wr_cnt_b - w0); else passes++;
      checks++; if (rd_cnt_b - r0 !== 4) $display("FAIL lat_rd_cycles: got %0d want 4", rd_cnt_b - r0); else passes++;
      checks++; if (rsp_wr_b !== 1'b0) $display("FAIL lat_rsp_wr: got %b want 0", rsp_wr_b); else passes++;
      checks++; if (rsp_data_b !== 32'hDEADBEEF) $display("FAIL lat_rdata: got %h want deadbeef", rsp_data_b); else passes++;
   endtask

   initial begin
      foreach (written[i]) written[i] = 1'b0;
      test_reset;
      test_write_single;
      test_read_back;
      test_back_to_back;
      test_alternate;
      test_random;
      test_reset_abort;
      test_read_latency;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
